flag_writer: RTL and testbench

- Producer side of the condition-flag interface: computes {Z,C,N,V} from the current ALU operands and op, holds them in an architectural flag register, and presents ALUFlags to the condition checker.
- Sits in the execute stage beside the ALU.
- Writes are gated by the CondEx and FlagW of the instruction in execute.
- A one-entry pending stage with bypass lets a conditional instruction in the very next cycle see flags set by its predecessor.

---
 rtl/flag_writer_pkg.sv | 33 +++
 rtl/flag_writer_if.sv | 34 +++
 rtl/flag_writer_gen.sv | 64 ++++++
 rtl/flag_writer.sv | 91 +++++++++
 tb/tb_flag_writer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/flag_writer_pkg.sv
// -----------------------------------------------------------------------------
// flag_pkg
// Shared definitions for the condition-flag producer: flag bit positions,
// ALU operation encodings, flag-write group masks and the {Z,C,N,V} record.
// -----------------------------------------------------------------------------
package flag_pkg;

  // Bit positions inside a 4-bit {Z,C,N,V} vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // FlagW group masks: bit1 covers N,Z and bit0 covers C,V
  localparam logic [1:0] FW_NZ  = 2'b10;
  localparam logic [1:0] FW_CV  = 2'b01;
  localparam logic [1:0] FW_ALL = 2'b11;

  // Packed flag record, same bit order as the 4-bit flag vectors
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flag_t;

endpackage

// File: rtl/flag_writer_if.sv
// -----------------------------------------------------------------------------
// flag_writer_if
// Execute-stage bundle between the pipeline control (master) and the flag
// producer (slave).
//   master drives : SrcA, SrcB, ALUControl, InstrValid, FlagW, CondEx,
//                   Stall, Flush
//   slave drives  : ALUFlags (bypassed view), ArchFlags (committed),
//                   FlagsCommitted (retire pulse)
// -----------------------------------------------------------------------------
interface flag_writer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [1:0]       ALUControl;
  logic             InstrValid;
  logic [1:0]       FlagW;
  logic             CondEx;
  logic             Stall;
  logic             Flush;
  logic [3:0]       ALUFlags;
  logic [3:0]       ArchFlags;
  logic             FlagsCommitted;

  modport master (
    output SrcA, SrcB, ALUControl, InstrValid, FlagW, CondEx, Stall, Flush,
    input  ALUFlags, ArchFlags, FlagsCommitted
  );

  modport slave (
    input  SrcA, SrcB, ALUControl, InstrValid, FlagW, CondEx, Stall, Flush,
    output ALUFlags, ArchFlags, FlagsCommitted
  );
endinterface

// File: rtl/flag_writer_gen.sv
// -----------------------------------------------------------------------------
// flag_gen
// Purely combinational {Z,C,N,V} generation from the ALU operands and op.
//   a_i, b_i      : operands (WIDTH bits)
//   alu_ctrl_i    : ALU_ADD / ALU_SUB / ALU_AND / ALU_ORR
//   flags_o       : generated {Z,C,N,V}
// -----------------------------------------------------------------------------
module flag_gen
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       alu_ctrl_i,
  output flag_t            flags_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;

  // Result, carry and overflow per operation
  always_comb begin
    sum_s = '0;
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (alu_ctrl_i)
      ALU_ADD: begin
        sum_s = {1'b0, a_i} + {1'b0, b_i};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (res_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        // Two's-complement subtract: carry out of A + ~B + 1 means no borrow
        sum_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (res_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: begin
        res_s = a_i & b_i;
      end
      ALU_ORR: begin
        res_s = a_i | b_i;
      end
      default: begin
        res_s = '0;
      end
    endcase
  end

  // Pack the flag record
  always_comb begin
    flags_o.z = (res_s == {WIDTH{1'b0}});
    flags_o.c = c_s;
    flags_o.n = res_s[WIDTH-1];
    flags_o.v = v_s;
  end

endmodule

// File: rtl/flag_writer.sv
// -----------------------------------------------------------------------------
// flag_writer
// Condition-flag producer beside the execute-stage ALU. Generated flags are
// captured into a one-entry pending stage together with a per-group write
// mask; on the following edge the pending entry retires into the
// architectural flag register. ALUFlags bypasses the pending entry so the
// next instruction sees its predecessor's flags one cycle early.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : flag_writer_if.slave (operands, qualifiers, flag outputs)
// -----------------------------------------------------------------------------
module flag_writer
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  flag_writer_if.slave  bus
);

  flag_t      gen_flags_s;
  logic       upd_s;
  logic [1:0] wmask_s;

  flag_t      arch_q;
  flag_t      arch_d;
  flag_t      pend_flags_q;
  logic [1:0] pend_mask_q;
  logic       committed_q;
  flag_t      bypass_s;

  flag_gen #(.WIDTH(WIDTH)) u_gen (
    .a_i        (bus.SrcA),
    .b_i        (bus.SrcB),
    .alu_ctrl_i (bus.ALUControl),
    .flags_o    (gen_flags_s)
  );

  // Write qualifier: only a live, passing, unstalled, unflushed instruction writes
  always_comb begin
    upd_s   = bus.InstrValid & bus.CondEx & ~bus.Stall & ~bus.Flush;
    wmask_s = bus.FlagW & {2{upd_s}};
  end

  // Per-group merge of the pending entry; shared by commit and bypass
  always_comb begin
    arch_d = arch_q;
    if ((pend_mask_q & FW_NZ) != 2'b00) begin
      arch_d.z = pend_flags_q.z;
      arch_d.n = pend_flags_q.n;
    end else begin
      arch_d.z = arch_q.z;
      arch_d.n = arch_q.n;
    end
    if ((pend_mask_q & FW_CV) != 2'b00) begin
      arch_d.c = pend_flags_q.c;
      arch_d.v = pend_flags_q.v;
    end else begin
      arch_d.c = arch_q.c;
      arch_d.v = arch_q.v;
    end
  end

  // Bypassed view equals the value ArchFlags will take at the next edge
  always_comb begin
    bypass_s = arch_d;
  end

  // Commit the pending entry and load the new one in the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_q       <= '0;
      pend_flags_q <= '0;
      pend_mask_q  <= 2'b00;
      committed_q  <= 1'b0;
    end else begin
      arch_q       <= arch_d;
      pend_flags_q <= gen_flags_s;
      pend_mask_q  <= wmask_s;
      committed_q  <= |pend_mask_q;
    end
  end

  // Drive the interface outputs
  always_comb begin
    bus.ALUFlags       = bypass_s;
    bus.ArchFlags      = arch_q;
    bus.FlagsCommitted = committed_q;
  end

endmodule

// File: tb/tb_flag_writer.sv
// -----------------------------------------------------------------------------
// tb_flag_writer
// Directed vectors with hand-computed {Z,C,N,V} expectations for flag_writer.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_flag_writer;
  import flag_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  int   pulses;

  flag_writer_if #(.WIDTH(32)) bus ();

  flag_writer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fw, input logic cond, input logic valid,
                       input logic stall, input logic flush);
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.FlagW      = fw;
    bus.CondEx     = cond;
    bus.InstrValid = valid;
    bus.Stall      = stall;
    bus.Flush      = flush;
  endtask

  task automatic idle();
    issue(ALU_ADD, 32'h0000_0000, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    pulses   = 0;
    reset    = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_alu",  {28'd0, bus.ALUFlags},  32'h0);
    check_eq("rst_arch", {28'd0, bus.ArchFlags}, 32'h0);
    check_eq("rst_fc",   {31'd0, bus.FlagsCommitted}, 32'h0);

    // Reset while a write is pending
    issue(ALU_SUB, 32'd5, 32'd5, FW_ALL, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_eq("pend_bypass", {28'd0, bus.ALUFlags}, 32'hC);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_alu",  {28'd0, bus.ALUFlags},  32'h0);
    check_eq("midrst_arch", {28'd0, bus.ArchFlags}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("midrst_arch2", {28'd0, bus.ArchFlags}, 32'h0);
    check_eq("midrst_fc",    {31'd0, bus.FlagsCommitted}, 32'h0);

    // SUB 5-5 latency
    issue(ALU_SUB, 32'd5, 32'd5, FW_ALL, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_eq("sub_t1_alu",  {28'd0, bus.ALUFlags},  32'hC);
    check_eq("sub_t1_arch", {28'd0, bus.ArchFlags}, 32'h0);
    check_eq("sub_t1_fc",   {31'd0, bus.FlagsCommitted}, 32'h0);
    tick();
    check_eq("sub_t2_arch", {28'd0, bus.ArchFlags}, 32'hC);
    check_eq("sub_t2_fc",   {31'd0, bus.FlagsCommitted}, 32'h1);
    check_eq("sub_t2_alu",  {28'd0, bus.ALUFlags},  32'hC);
    tick();
    check_eq("sub_t3_fc",   {31'd0, bus.FlagsCommitted}, 32'h0);

    // Back-to-back ADD overflow then ADD carry/zero
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, FW_ALL, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("add1_alu",  {28'd0, bus.ALUFlags},  32'h3);
    check_eq("add1_arch", {28'd0, bus.ArchFlags}, 32'hC);
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, FW_ALL, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_eq("add2_alu",  {28'd0, bus.ALUFlags},  32'hC);
    check_eq("add2_arch", {28'd0, bus.ArchFlags}, 32'h3);
    check_eq("add2_fc",   {31'd0, bus.FlagsCommitted}, 32'h1);
    tick();
    check_eq("add3_arch", {28'd0, bus.ArchFlags}, 32'hC);
    check_eq("add3_fc",   {31'd0, bus.FlagsCommitted}, 32'h1);
    tick();
    check_eq("add4_fc",   {31'd0, bus.FlagsCommitted}, 32'h0);

    // Partial N,Z writes merge with retained C,V
    issue(ALU_AND, 32'h0000_00F0, 32'h0000_000F, FW_NZ, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_eq("and_alu", {28'd0, bus.ALUFlags}, 32'hC);
    tick();
    check_eq("and_arch", {28'd0, bus.ArchFlags}, 32'hC);
    issue(ALU_ORR, 32'h8000_0000, 32'h0000_0000, FW_NZ, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_eq("orr_alu", {28'd0, bus.ALUFlags}, 32'h6);
    tick();
    check_eq("orr_arch", {28'd0, bus.ArchFlags}, 32'h6);
    tick();

    // Gated writers: CondEx=0, Flush, Stall, InstrValid=0, FlagW=00
    for (int g = 0; g < 5; g++) begin
      case (g)
        0: issue(ALU_SUB, 32'd3, 32'd5, FW_ALL, 1'b0, 1'b1, 1'b0, 1'b0);
        1: issue(ALU_SUB, 32'd3, 32'd5, FW_ALL, 1'b1, 1'b1, 1'b0, 1'b1);
        2: issue(ALU_SUB, 32'd3, 32'd5, FW_ALL, 1'b1, 1'b1, 1'b1, 1'b0);
        3: issue(ALU_SUB, 32'd3, 32'd5, FW_ALL, 1'b1, 1'b0, 1'b0, 1'b0);
        default: issue(ALU_SUB, 32'd3, 32'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      endcase
      tick();
      idle();
      check_eq($sformatf("gate%0d_alu", g), {28'd0, bus.ALUFlags}, 32'h6);
      check_eq($sformatf("gate%0d_fc", g), {31'd0, bus.FlagsCommitted}, 32'h0);
      tick();
      check_eq($sformatf("gate%0d_arch", g), {28'd0, bus.ArchFlags}, 32'h6);
      check_eq($sformatf("gate%0d_fc2", g), {31'd0, bus.FlagsCommitted}, 32'h0);
    end

    // Stall for three cycles, then release: exactly one write
    pulses = 0;
    issue(ALU_SUB, 32'd1, 32'd2, FW_ALL, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq($sformatf("stall%0d_alu", s), {28'd0, bus.ALUFlags}, 32'h6);
      if (bus.FlagsCommitted === 1'b1) pulses = pulses + 1;
    end
    bus.Stall = 1'b0;
    tick();
    idle();
    check_eq("rel_alu", {28'd0, bus.ALUFlags}, 32'h2);
    if (bus.FlagsCommitted === 1'b1) pulses = pulses + 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        check_eq("rel_arch", {28'd0, bus.ArchFlags}, 32'h2);
      end else begin
        check_eq($sformatf("rel_arch_hold%0d", k), {28'd0, bus.ArchFlags}, 32'h2);
      end
      if (bus.FlagsCommitted === 1'b1) pulses = pulses + 1;
    end
    check_eq("rel_pulses", pulses, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
